// File: rtl/sr_pkg.sv
// Shared definitions for the SR flip-flop drive controller.
// Holds the FSM state encoding, the {s,r} command encoding and the duration
// counter width used by sr_drive_ctrl and sr_cyc_cnt.
package sr_pkg;

  // Width of the DRIVE/SETTLE duration counter; covers lengths up to 15 cycles.
  localparam int unsigned CNT_W = 4;

  typedef enum logic [2:0] {
    StIdle,
    StDrive,
    StSettle,
    StCheck,
    StDone
  } sr_state_e;

  // Bit 1 is s, bit 0 is r. CmdInv is listed for completeness and never issued.
  typedef enum logic [1:0] {
    CmdHold = 2'b00,
    CmdRst  = 2'b01,
    CmdSet  = 2'b10,
    CmdInv  = 2'b11
  } sr_cmd_e;

  // Command that drives the flip-flop towards state d.
  function automatic sr_cmd_e drive_cmd(input logic d);
    return d ? CmdSet : CmdRst;
  endfunction

endpackage

// File: rtl/sr_drive_ctrl_if.sv
// Request/completion handshake between a requester and sr_drive_ctrl.
// Signals:
//   req_valid - target-state request present (requester -> controller)
//   req_d     - requested flip-flop state     (requester -> controller)
//   req_ready - controller can accept          (controller -> requester)
//   done      - one-cycle completion pulse     (controller -> requester)
//   err       - last request failed verification (controller -> requester)
// Modports: master = requester side, slave = controller side.
interface sr_drive_ctrl_if;

  logic req_valid;
  logic req_d;
  logic req_ready;
  logic done;
  logic err;

  modport master (
    output req_valid,
    output req_d,
    input  req_ready,
    input  done,
    input  err
  );

  modport slave (
    input  req_valid,
    input  req_d,
    output req_ready,
    output done,
    output err
  );

endinterface

// File: rtl/sr_cyc_cnt.sv
// Loadable down-counter timing the DRIVE and SETTLE phases.
// Ports:
//   clk      - clock, rising edge
//   rst      - asynchronous active-high reset, clears the count
//   load     - load load_val this cycle (has priority over counting)
//   load_val - value loaded; a phase of N cycles loads N-1
//   zero     - count has reached zero (last cycle of the phase)
module sr_cyc_cnt
  import sr_pkg::*;
(
  input  logic             clk,
  input  logic             rst,
  input  logic             load,
  input  logic [CNT_W-1:0] load_val,
  output logic             zero
);

  logic [CNT_W-1:0] cnt_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt_q <= '0;
    end else if (load) begin
      cnt_q <= load_val;
    end else if (cnt_q != '0) begin
      cnt_q <= cnt_q - CNT_W'(1);
    end
  end

  assign zero = (cnt_q == '0);

endmodule

// File: rtl/sr_drive_ctrl.sv
// Controller that drives an external SR flip-flop to a requested state.
// A request is accepted in IDLE; if the flip-flop is already known to hold the
// target, the controller completes at once without touching s/r. Otherwise it
// pulses s (target 1) or r (target 0) for PULSE_CYC cycles, idles SETTLE_CYC
// cycles and, with verification enabled, checks q_fb and retries up to
// MAX_RETRY times before flagging err.
// Build option: define SR_DRIVE_VERIFY_EN to include the CHECK state, retries
// and err. Without it q_fb is ignored, err is tied low and the drive is
// assumed to succeed.
// Ports:
//   clk  - clock, rising edge
//   rst  - asynchronous active-high reset; drops s/r immediately
//   bus  - request handshake (req_valid, req_d, req_ready, done, err)
//   s, r - set/reset drive to the flip-flop, never both high
//   q_fb - flip-flop Q fed back
module sr_drive_ctrl
  import sr_pkg::*;
#(
  parameter int unsigned PULSE_CYC  = 2,
  parameter int unsigned SETTLE_CYC = 1,
  parameter int unsigned MAX_RETRY  = 2
) (
  input  logic            clk,
  input  logic            rst,
  sr_drive_ctrl_if.slave  bus,
  output logic            s,
  output logic            r,
  input  logic            q_fb
);

  localparam logic [CNT_W-1:0] PulseLd  = CNT_W'(PULSE_CYC - 1);
  localparam logic [CNT_W-1:0] SettleLd = (SETTLE_CYC == 0) ? '0 : CNT_W'(SETTLE_CYC - 1);

  sr_state_e        state_q;
  sr_cmd_e          cmd_q;
  logic             done_q;
  logic             target_q;
  logic             cur_q;
  logic             known_q;

  logic             cnt_load;
  logic [CNT_W-1:0] cnt_val;
  logic             cnt_zero;
  logic             noop;
  logic             phase_end;

`ifdef SR_DRIVE_VERIFY_EN
  localparam logic [2:0] MaxRetry = 3'(MAX_RETRY);
  logic [2:0] retry_q;
  logic       err_q;
  logic       fb_miss;
  assign fb_miss = (q_fb != target_q);
  assign bus.err = err_q;
`else
  logic unused_q_fb;
  assign unused_q_fb = q_fb;
  assign bus.err     = 1'b0;
`endif

  // Flip-flop already holds the requested value: nothing to drive.
  assign noop = known_q && (bus.req_d == cur_q);

  // Last cycle before leaving the drive/settle sequence.
  assign phase_end = cnt_zero &&
                     ((state_q == StSettle) || ((state_q == StDrive) && (SETTLE_CYC == 0)));

  always_comb begin
    cnt_load = 1'b0;
    cnt_val  = PulseLd;
    unique case (state_q)
      StIdle:  cnt_load = bus.req_valid && !noop;
      StDrive: begin
        if (cnt_zero && (SETTLE_CYC != 0)) begin
          cnt_load = 1'b1;
          cnt_val  = SettleLd;
        end
      end
`ifdef SR_DRIVE_VERIFY_EN
      StCheck: cnt_load = fb_miss && (retry_q < MaxRetry);
`endif
      default: ;
    endcase
  end

  sr_cyc_cnt u_cyc_cnt (
    .clk      (clk),
    .rst      (rst),
    .load     (cnt_load),
    .load_val (cnt_val),
    .zero     (cnt_zero)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= StIdle;
      cmd_q    <= CmdHold;
      done_q   <= 1'b0;
      target_q <= 1'b0;
      cur_q    <= 1'b0;
      known_q  <= 1'b0;
`ifdef SR_DRIVE_VERIFY_EN
      retry_q  <= '0;
      err_q    <= 1'b0;
`endif
    end else begin
      done_q <= 1'b0;
      unique case (state_q)
        StIdle: begin
          if (bus.req_valid) begin
            target_q <= bus.req_d;
`ifdef SR_DRIVE_VERIFY_EN
            retry_q  <= '0;
            err_q    <= 1'b0;
`endif
            if (noop) begin
              state_q <= StDone;
              done_q  <= 1'b1;
            end else begin
              state_q <= StDrive;
              cmd_q   <= drive_cmd(bus.req_d);
            end
          end
        end
        StDrive, StSettle: begin
          if ((state_q == StDrive) && cnt_zero) begin
            cmd_q   <= CmdHold;
            state_q <= StSettle;
          end
          // Later assignments override the SETTLE move when settle is skipped.
          if (phase_end) begin
`ifdef SR_DRIVE_VERIFY_EN
            state_q <= StCheck;
`else
            state_q <= StDone;
            done_q  <= 1'b1;
            cur_q   <= target_q;
            known_q <= 1'b1;
`endif
          end
        end
`ifdef SR_DRIVE_VERIFY_EN
        StCheck: begin
          if (!fb_miss) begin
            cur_q   <= target_q;
            known_q <= 1'b1;
            state_q <= StDone;
            done_q  <= 1'b1;
          end else if (retry_q < MaxRetry) begin
            retry_q <= retry_q + 3'd1;
            cmd_q   <= drive_cmd(target_q);
            state_q <= StDrive;
          end else begin
            err_q   <= 1'b1;
            known_q <= 1'b0;
            state_q <= StDone;
            done_q  <= 1'b1;
          end
        end
`endif
        StDone:  state_q <= StIdle;
        default: state_q <= StIdle;
      endcase
    end
  end

  assign s             = cmd_q[1];
  assign r             = cmd_q[0];
  assign bus.req_ready = (state_q == StIdle);
  assign bus.done      = done_q;

endmodule

// File: tb/tb_sr_drive_ctrl.sv
// Scoreboard bench for sr_drive_ctrl (PULSE_CYC=2, SETTLE_CYC=1, MAX_RETRY=2).
// Expected latencies follow SR_DRIVE_VERIFY_EN so both builds are covered.
module tb_sr_drive_ctrl;

  localparam int unsigned P = 2;
  localparam int unsigned S = 1;
  localparam int unsigned M = 2;

`ifdef SR_DRIVE_VERIFY_EN
  localparam int   LatDrv      = 5;
  localparam int   LatRetry    = 13;
  localparam int   RetryPulses = 3;
  localparam logic ErrRetry    = 1'b1;
`else
  localparam int   LatDrv      = 4;
  localparam int   LatRetry    = 4;
  localparam int   RetryPulses = 1;
  localparam logic ErrRetry    = 1'b0;
`endif

  typedef struct {
    int   lat;
    logic err;
    int   s_cyc;
    int   r_cyc;
    int   s_pls;
    int   r_pls;
  } exp_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic s, r, q_fb;
  logic ff = 1'b0;
  logic stuck = 1'b0;

  int   n_checks = 0;
  int   n_fail = 0;
  int   accept_cnt = 0;
  bit   in_flight = 0;
  exp_t sb[$];

  sr_drive_ctrl_if bus ();

  sr_drive_ctrl #(
    .PULSE_CYC  (P),
    .SETTLE_CYC (S),
    .MAX_RETRY  (M)
  ) dut (
    .clk  (clk),
    .rst  (rst),
    .bus  (bus),
    .s    (s),
    .r    (r),
    .q_fb (q_fb)
  );

  always #5 clk = ~clk;

  // External SR flip-flop model; stuck forces Q high.
  always @(posedge clk) begin
    if (s) ff <= 1'b1;
    else if (r) ff <= 1'b0;
  end
  assign q_fb = stuck ? 1'b1 : ff;

  task automatic chk(input string name, input int act, input int exp);
    n_checks++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  function automatic exp_t mk(input int lat, input logic err, input int sc, input int rc,
                              input int sp, input int rp);
    exp_t e;
    e.lat = lat; e.err = err; e.s_cyc = sc; e.r_cyc = rc; e.s_pls = sp; e.r_pls = rp;
    return e;
  endfunction

  // Tracks each accepted request and compares against the scoreboard at done.
  task automatic monitor();
    exp_t e;
    int   cyc = 0, sc = 0, rc = 0, sp = 0, rp = 0;
    logic s_prev = 1'b0, r_prev = 1'b0;
    forever begin
      @(posedge clk);
      if (!rst && bus.req_valid && bus.req_ready) begin
        in_flight = 1; cyc = 0; sc = 0; rc = 0; sp = 0; rp = 0;
        accept_cnt++;
      end
      @(negedge clk);
      chk("s_and_r", int'(s & r), 0);
      if (rst) begin
        in_flight = 0;
      end else if (in_flight) begin
        cyc++;
        if (s) sc++;
        if (r) rc++;
        if (s && !s_prev) sp++;
        if (r && !r_prev) rp++;
        if (bus.done) begin
          in_flight = 0;
          if (sb.size() == 0) begin
            chk("done_unexpected", 1, 0);
          end else begin
            e = sb.pop_front();
            chk("latency", cyc, e.lat);
            chk("err_at_done", int'(bus.err), int'(e.err));
            chk("s_cycles", sc, e.s_cyc);
            chk("r_cycles", rc, e.r_cyc);
            chk("s_pulses", sp, e.s_pls);
            chk("r_pulses", rp, e.r_pls);
          end
        end
      end else if (bus.done) begin
        chk("done_unexpected", 1, 0);
      end
      s_prev = s;
      r_prev = r;
    end
  endtask

  task automatic issue(input logic d, input exp_t e);
    int start;
    bit ok;
    ok = 0;
    @(negedge clk);
    start = accept_cnt;
    bus.req_valid = 1'b1;
    bus.req_d     = d;
    sb.push_back(e);
    for (int i = 0; i < 50; i++) begin
      @(posedge clk);
      #1;
      if (accept_cnt != start) begin
        ok = 1;
        break;
      end
    end
    bus.req_valid = 1'b0;
    bus.req_d     = ~d;  // must not affect the accepted request
    chk("accept_seen", int'(ok), 1);
  endtask

  task automatic wait_idle();
    bit ok;
    ok = 0;
    for (int i = 0; i < 100; i++) begin
      @(negedge clk);
      if (sb.size() == 0 && !in_flight) begin
        ok = 1;
        break;
      end
    end
    chk("complete_in_time", int'(ok), 1);
    repeat (2) @(negedge clk);
  endtask

  initial begin
    int start;
    bit ok;
    bus.req_valid = 1'b0;
    bus.req_d     = 1'b0;
    fork
      monitor();
    join_none

    rst = 1'b1;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    chk("rst_ready", int'(bus.req_ready), 1);
    chk("rst_s", int'(s), 0);
    chk("rst_r", int'(r), 0);
    chk("rst_done", int'(bus.done), 0);
    chk("rst_err", int'(bus.err), 0);

    // Unknown state: full drive of 1.
    issue(1'b1, mk(LatDrv, 1'b0, P, 0, 1, 0));
    wait_idle();

    // Known 1 requested again: no-op.
    issue(1'b1, mk(1, 1'b0, 0, 0, 0, 0));
    wait_idle();

    // Drive 0 while Q is stuck high.
    stuck = 1'b1;
    issue(1'b0, mk(LatRetry, ErrRetry, 0, RetryPulses * P, 0, RetryPulses));
    wait_idle();
    chk("err_hold", int'(bus.err), int'(ErrRetry));

    // Request 1 is driven again and clears err.
    stuck = 1'b0;
    issue(1'b1, mk(LatDrv, 1'b0, P, 0, 1, 0));
    wait_idle();
    chk("err_cleared", int'(bus.err), 0);

    // Reset in the second DRIVE cycle of a drive-to-0; no done may follow.
    @(negedge clk);
    start = accept_cnt;
    bus.req_valid = 1'b1;
    bus.req_d     = 1'b0;
    @(posedge clk);
    #1;
    bus.req_valid = 1'b0;
    chk("abort_accepted", accept_cnt - start, 1);
    @(posedge clk);
    #1;
    chk("abort_r_before", int'(r), 1);
    rst = 1'b1;
    #1;
    chk("abort_r_async", int'(r), 0);
    chk("abort_s_async", int'(s), 0);
    repeat (2) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    chk("abort_ready", int'(bus.req_ready), 1);
    repeat (6) @(negedge clk);

    // State is unknown after reset, so 1 is driven.
    issue(1'b1, mk(LatDrv, 1'b0, P, 0, 1, 0));
    wait_idle();

    // req_valid held high: two no-ops, one per IDLE visit.
    @(negedge clk);
    start = accept_cnt;
    sb.push_back(mk(1, 1'b0, 0, 0, 0, 0));
    sb.push_back(mk(1, 1'b0, 0, 0, 0, 0));
    bus.req_valid = 1'b1;
    bus.req_d     = 1'b1;
    ok = 0;
    for (int i = 0; i < 20; i++) begin
      @(posedge clk);
      #1;
      if (accept_cnt - start == 2) begin
        ok = 1;
        break;
      end
    end
    bus.req_valid = 1'b0;
    chk("held_two_accepts", int'(ok), 1);
    wait_idle();

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
